// File: rtl/bus_channel_controller.sv
// 6809 bus-cycle controller: decodes the CPU address into channels, issues a request,
// stretches the cycle with MRDY until ack or timeout, and drives registered read data.
module bus_channel_controller #(
    parameter int unsigned                 NUM_CH      = 4,
    parameter int unsigned                 ADDR_W      = 16,
    parameter int unsigned                 DATA_W      = 8,
    parameter logic [NUM_CH*ADDR_W-1:0]    CH_BASE     = {16'hF000, 16'hC000, 16'hA000, 16'h0000},
    parameter logic [NUM_CH*ADDR_W-1:0]    CH_MASK     = {16'hF000, 16'hFFFC, 16'hE000, 16'hF000},
    parameter int unsigned                 TIMEOUT     = 255,
    parameter int unsigned                 SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        i_ADDRESS_BUS,
    input  logic                     i_RW,
    input  logic                     i_E,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_data_oe,
    output logic                     o_MRDY,
    output logic [NUM_CH-1:0]        o_ch_sel,
    output logic                     o_ch_req,
    output logic                     o_ch_rw,
    output logic [ADDR_W-1:0]        o_ch_addr,
    output logic [DATA_W-1:0]        o_ch_wdata,
    input  logic [NUM_CH-1:0]        i_ch_ack,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_rdata,
    output logic                     o_timeout,
    output logic [2:0]               o_timeout_ch,
    input  logic                     i_timeout_clr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CH_W  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  e_sync;
    logic                    e_prev;
    logic                    e_rise;
    logic                    e_fall;
    logic [CH_W-1:0]         ch_q;
    logic [CNT_W-1:0]        cnt;

    logic                    hit_c;
    logic [CH_W-1:0]         hit_ch_c;
    logic                    ack_sel_c;
    logic [DATA_W-1:0]       rdata_sel_c;
    logic                    to_hit_c;

    // E synchroniser with registered edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_sync <= '0;
            e_prev <= 1'b0;
            e_rise <= 1'b0;
            e_fall <= 1'b0;
        end else begin
            e_sync <= {e_sync[SYNC_STAGES-2:0], i_E};
            e_prev <= e_sync[SYNC_STAGES-1];
            e_rise <= e_sync[SYNC_STAGES-1] & ~e_prev;
            e_fall <= ~e_sync[SYNC_STAGES-1] & e_prev;
        end
    end

    // Address decode; iterating downwards leaves the lowest matching index
    always_comb begin
        hit_c    = 1'b0;
        hit_ch_c = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((i_ADDRESS_BUS & CH_MASK[i*ADDR_W +: ADDR_W]) ==
                (CH_BASE[i*ADDR_W +: ADDR_W] & CH_MASK[i*ADDR_W +: ADDR_W])) begin
                hit_c    = 1'b1;
                hit_ch_c = CH_W'(i);
            end
        end
    end

    // Ack and read data of the selected channel only
    always_comb begin
        ack_sel_c   = 1'b0;
        rdata_sel_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                ack_sel_c   = i_ch_ack[i];
                rdata_sel_c = i_ch_rdata[i*DATA_W +: DATA_W];
            end
        end
        to_hit_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ch_q         <= '0;
            cnt          <= '0;
            o_data       <= '0;
            o_data_oe    <= 1'b0;
            o_MRDY       <= 1'b1;
            o_ch_sel     <= '0;
            o_ch_req     <= 1'b0;
            o_ch_rw      <= 1'b1;
            o_ch_addr    <= '0;
            o_ch_wdata   <= '0;
            o_timeout    <= 1'b0;
            o_timeout_ch <= '0;
        end else begin
            o_ch_req <= 1'b0;
            // A timeout raised below in WAIT overrides this clear
            if (i_timeout_clr) begin
                o_timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (e_rise) begin
                        o_ch_addr  <= i_ADDRESS_BUS;
                        o_ch_rw    <= i_RW;
                        o_ch_wdata <= i_data;
                        if (hit_c) begin
                            ch_q     <= hit_ch_c;
                            o_ch_sel <= NUM_CH'(1) << hit_ch_c;
                            o_ch_req <= 1'b1;
                            o_MRDY   <= 1'b0;
                            cnt      <= '0;
                            state    <= REQ;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                REQ: begin
                    cnt <= CNT_W'(1);
                    if (ack_sel_c) begin
                        if (o_ch_rw) begin
                            o_data <= rdata_sel_c;
                        end
                        o_data_oe <= o_ch_rw;
                        o_MRDY    <= 1'b1;
                        state     <= DONE;
                    end else if (e_fall) begin
                        o_ch_sel <= '0;
                        o_MRDY   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_sel_c) begin
                        if (o_ch_rw) begin
                            o_data <= rdata_sel_c;
                        end
                        o_data_oe <= o_ch_rw;
                        o_MRDY    <= 1'b1;
                        state     <= DONE;
                    end else if (to_hit_c) begin
                        o_timeout    <= 1'b1;
                        o_timeout_ch <= ch_q;
                        if (o_ch_rw) begin
                            o_data <= '1;
                        end
                        o_data_oe <= o_ch_rw;
                        o_MRDY    <= 1'b1;
                        state     <= DONE;
                    end else if (e_fall) begin
                        o_ch_sel <= '0;
                        o_MRDY   <= 1'b1;
                        state    <= IDLE;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (e_fall) begin
                        o_data_oe <= 1'b0;
                        o_ch_sel  <= '0;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (e_fall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_channel_controller.sv
// Randomised bench for bus_channel_controller against a transaction-level model
// of decode, MRDY stretch length, read data and the sticky timeout flag.
module tb_bus_channel_controller;

    localparam int NCH = 4;
    localparam int T   = 8;
    localparam int SS  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_ADDRESS_BUS;
    logic        i_RW;
    logic        i_E;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_data_oe;
    logic        o_MRDY;
    logic [3:0]  o_ch_sel;
    logic        o_ch_req;
    logic        o_ch_rw;
    logic [15:0] o_ch_addr;
    logic [7:0]  o_ch_wdata;
    logic [3:0]  i_ch_ack;
    logic [31:0] i_ch_rdata;
    logic        o_timeout;
    logic [2:0]  o_timeout_ch;
    logic        i_timeout_clr;

    bus_channel_controller #(.TIMEOUT(T), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_RW(i_RW), .i_E(i_E),
        .i_data(i_data), .o_data(o_data), .o_data_oe(o_data_oe), .o_MRDY(o_MRDY),
        .o_ch_sel(o_ch_sel), .o_ch_req(o_ch_req), .o_ch_rw(o_ch_rw), .o_ch_addr(o_ch_addr),
        .o_ch_wdata(o_ch_wdata), .i_ch_ack(i_ch_ack), .i_ch_rdata(i_ch_rdata),
        .o_timeout(o_timeout), .o_timeout_ch(o_timeout_ch), .i_timeout_clr(i_timeout_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Address map as a table: lowest matching entry wins
    logic [15:0] m_base [NCH] = '{16'h0000, 16'hA000, 16'hC000, 16'hF000};
    logic [15:0] m_mask [NCH] = '{16'hF000, 16'hE000, 16'hFFFC, 16'hF000};

    logic [7:0] exp_data  = 8'h00;
    logic       exp_to    = 1'b0;
    logic [2:0] exp_to_ch = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < NCH; i++) begin
            if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
        end
        return -1;
    endfunction

    // One full E cycle; ack_delay < 0 means the target never acks
    task automatic run_txn(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                           input int ack_delay, input logic [3:0] noise);
        int         ch;
        int         low;
        int         reqs;
        int         req_idx;
        int         exp_low;
        logic       to_now;
        logic       mrdy_prev;
        logic       exp_oe;
        logic [3:0] onehot;
        logic [3:0] sel_at_req;
        logic [3:0] ack;
        logic [7:0] rd [NCH];

        ch     = decode(addr);
        onehot = (ch >= 0) ? 4'(1 << ch) : 4'd0;
        for (int k = 0; k < NCH; k++) rd[k] = 8'($urandom);
        to_now  = 1'b0;
        exp_low = 0;
        if (ch >= 0) begin
            if (ack_delay >= 0 && ack_delay <= T) begin
                exp_low = ack_delay + 1;
                if (rw) exp_data = rd[ch];
            end else begin
                exp_low   = T + 1;
                to_now    = 1'b1;
                exp_to    = 1'b1;
                exp_to_ch = 3'(ch);
                if (rw) exp_data = 8'hFF;
            end
        end
        exp_oe = (ch >= 0) && rw;

        @(negedge clk);
        i_ADDRESS_BUS = addr;
        i_RW          = rw;
        i_data        = wd;
        i_ch_rdata    = {rd[3], rd[2], rd[1], rd[0]};
        i_ch_ack      = 4'd0;
        i_E           = 1'b1;
        reqs = 0; low = 0; req_idx = -1; sel_at_req = 4'd0; mrdy_prev = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (o_ch_req) begin
                reqs++;
                if (req_idx < 0) begin
                    req_idx    = n;
                    sel_at_req = o_ch_sel;
                end
            end
            if (!o_MRDY) low++;
            if (!mrdy_prev && o_MRDY) begin
                check("oe_at_mrdy_rise", 32'(o_data_oe), 32'(rw));
                if (to_now) check("timeout_with_mrdy", 32'(o_timeout), 32'd1);
            end
            mrdy_prev = o_MRDY;
            ack = noise & ~onehot;
            if (ch >= 0 && req_idx >= 0 && ack_delay >= 0 && (n - req_idx) >= ack_delay)
                ack = ack | onehot;
            i_ch_ack = ack;
        end

        check("req_count", 32'(reqs), (ch >= 0) ? 32'd1 : 32'd0);
        if (ch >= 0) begin
            check("req_latency", 32'(req_idx), 32'(SS + 1));
            check("sel_at_req", 32'(sel_at_req), 32'(onehot));
        end
        check("mrdy_low_cycles", 32'(low), 32'(exp_low));
        check("mrdy_end", 32'(o_MRDY), 32'd1);
        check("data", 32'(o_data), 32'(exp_data));
        check("data_oe", 32'(o_data_oe), 32'(exp_oe));
        check("ch_sel_held", 32'(o_ch_sel), 32'(onehot));
        check("ch_addr", 32'(o_ch_addr), 32'(addr));
        check("ch_rw", 32'(o_ch_rw), 32'(rw));
        check("ch_wdata", 32'(o_ch_wdata), 32'(wd));
        check("timeout", 32'(o_timeout), 32'(exp_to));
        check("timeout_ch", 32'(o_timeout_ch), 32'(exp_to_ch));

        i_E      = 1'b0;
        i_ch_ack = 4'd0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == SS) check("oe_before_fall", 32'(o_data_oe), 32'(exp_oe));
            if (n == SS + 1) begin
                check("oe_after_fall", 32'(o_data_oe), 32'd0);
                check("sel_after_fall", 32'(o_ch_sel), 32'd0);
            end
        end
    endtask

    task automatic clear_timeout();
        @(negedge clk);
        i_timeout_clr = 1'b1;
        @(negedge clk);
        i_timeout_clr = 1'b0;
        exp_to = 1'b0;
        check("timeout_clr", 32'(o_timeout), 32'd0);
    endtask

    initial begin
        reset = 1'b0; i_ADDRESS_BUS = '0; i_RW = 1'b1; i_E = 1'b0; i_data = '0;
        i_ch_ack = '0; i_ch_rdata = '0; i_timeout_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mrdy", 32'(o_MRDY), 32'd1);
        check("rst_oe", 32'(o_data_oe), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_sel", 32'(o_ch_sel), 32'd0);
        check("rst_req", 32'(o_ch_req), 32'd0);
        check("rst_rw", 32'(o_ch_rw), 32'd1);
        check("rst_addr", 32'(o_ch_addr), 32'd0);
        check("rst_wdata", 32'(o_ch_wdata), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_timeout_ch", 32'(o_timeout_ch), 32'd0);
        reset = 1'b1;

        run_txn(16'h0123, 1'b1, 8'h00, 3, 4'b0000);
        run_txn(16'hA010, 1'b0, 8'hC3, 0, 4'b0000);
        run_txn(16'h5000, 1'b1, 8'h11, 0, 4'b1111);
        run_txn(16'hF800, 1'b1, 8'h00, -1, 4'b0000);
        clear_timeout();
        run_txn(16'h0100, 1'b1, 8'h00, -1, 4'b0100);
        run_txn(16'hC002, 1'b1, 8'h00, T, 4'b1011);
        clear_timeout();

        // Reset in the middle of a stretched cycle
        @(negedge clk);
        i_ADDRESS_BUS = 16'h0200; i_RW = 1'b1; i_E = 1'b1; i_ch_ack = 4'd0;
        repeat (6) @(negedge clk);
        check("pre_rst_mrdy_low", 32'(o_MRDY), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("midrst_mrdy", 32'(o_MRDY), 32'd1);
        check("midrst_sel", 32'(o_ch_sel), 32'd0);
        check("midrst_oe", 32'(o_data_oe), 32'd0);
        exp_data = 8'h00; exp_to = 1'b0; exp_to_ch = 3'd0;
        i_E = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_txn(16'h0456, 1'b1, 8'h00, 2, 4'b0000);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] a;
            int          d;
            case ($urandom_range(0, 3))
                0:       a = {4'h0, 12'($urandom)};
                1:       a = 16'hC000 + 16'($urandom_range(0, 3));
                default: a = 16'($urandom);
            endcase
            d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
            run_txn(a, 1'($urandom), 8'($urandom), d, 4'($urandom));
            if (exp_to && $urandom_range(0, 1) == 1) clear_timeout();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
